// File: rtl/fma16_mul_stage_if.sv
// fma16 multiply stage handshake bundle.
// Operand side flows in, product side flows out.
interface fma16_mul_stage_if #(
  parameter int NBITS = 11
);
  logic               in_valid;
  logic               in_ready;
  logic               Xs;
  logic               Ys;
  logic [4:0]         Xe;
  logic [4:0]         Ye;
  logic [NBITS-1:0]   Xm;
  logic [NBITS-1:0]   Ym;
  logic               Xzero;
  logic               Xinf;
  logic               XNaN;
  logic               XsNaN;
  logic               Yzero;
  logic               Yinf;
  logic               YNaN;
  logic               YsNaN;
  logic               out_valid;
  logic               out_ready;
  logic               Ps;
  logic [6:0]         Pe;
  logic [2*NBITS-1:0] Pm;
  logic               Pzero;
  logic               Pinf;
  logic               PNaN;
  logic               Pinvalid;

  modport slave (
    input  in_valid, Xs, Ys, Xe, Ye, Xm, Ym,
    input  Xzero, Xinf, XNaN, XsNaN,
    input  Yzero, Yinf, YNaN, YsNaN,
    input  out_ready,
    output in_ready, out_valid,
    output Ps, Pe, Pm,
    output Pzero, Pinf, PNaN, Pinvalid
  );

  modport master (
    output in_valid, Xs, Ys, Xe, Ye, Xm, Ym,
    output Xzero, Xinf, XNaN, XsNaN,
    output Yzero, Yinf, YNaN, YsNaN,
    output out_ready,
    input  in_ready, out_valid,
    input  Ps, Pe, Pm,
    input  Pzero, Pinf, PNaN, Pinvalid
  );
endinterface

// File: rtl/fma16_mul_stage.sv
// fma16 multiply stage: radix-2 shift-add
// significand multiplier plus special-case flags.
module fma16_mul_stage #(
  parameter int BIAS  = 15,
  parameter int NBITS = 11
) (
  input logic              clk,
  input logic              rst_n,
  fma16_mul_stage_if.slave io
);

  localparam int CW = $clog2(NBITS);
  localparam int PW = 2 * NBITS;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    SPEC,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]    cnt_q;
  logic [NBITS:0]   acc_q;
  logic [NBITS-1:0] mcand_q;
  logic [NBITS-1:0] mpl_q;
  logic [PW-1:0]    pm_q;
  logic [6:0]       pe_q;
  logic             ps_q;
  logic             pz_q, pi_q, pn_q, pv_q;
  logic             xz_q, xi_q, xn_q, xsn_q;
  logic             yz_q, yi_q, yn_q, ysn_q;

  logic             accept;
  logic             special_in;
  logic             last_it;
  logic [6:0]       pe_sum;
  logic [NBITS:0]   add_d;
  logic [PW-1:0]    prod_d;
  logic             any_nan;
  logic             inf_zero;

  assign accept     = (state_q == IDLE) && io.in_valid;
  assign special_in = io.Xzero | io.Yzero |
                      io.Xinf  | io.Yinf  |
                      io.XNaN  | io.YNaN  |
                      io.XsNaN | io.YsNaN;
  assign last_it    = (cnt_q == CW'(NBITS - 1));
  assign pe_sum     = {2'b00, io.Xe} + {2'b00, io.Ye}
                    - 7'(BIAS);

  // one shift-add step; final step yields the product
  assign add_d  = acc_q + (mpl_q[0] ? {1'b0, mcand_q}
                                    : '0);
  assign prod_d = {add_d, mpl_q[NBITS-1:1]};

  assign any_nan  = xn_q | yn_q | xsn_q | ysn_q;
  assign inf_zero = (xi_q & yz_q) | (yi_q & xz_q);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (io.in_valid)
              state_d = special_in ? SPEC : BUSY;
      BUSY: if (last_it) state_d = DONE;
      SPEC: state_d = DONE;
      DONE: if (io.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // handshake outputs from state
  always_comb begin
    io.in_ready  = (state_q == IDLE);
    io.out_valid = (state_q == DONE);
  end

  // operand capture, iteration and special results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      mpl_q   <= '0;
      pm_q    <= '0;
      pe_q    <= '0;
      ps_q    <= 1'b0;
      pz_q    <= 1'b0;
      pi_q    <= 1'b0;
      pn_q    <= 1'b0;
      pv_q    <= 1'b0;
      xz_q    <= 1'b0;
      xi_q    <= 1'b0;
      xn_q    <= 1'b0;
      xsn_q   <= 1'b0;
      yz_q    <= 1'b0;
      yi_q    <= 1'b0;
      yn_q    <= 1'b0;
      ysn_q   <= 1'b0;
    end else if (accept) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= io.Xm;
      mpl_q   <= io.Ym;
      pe_q    <= pe_sum;
      ps_q    <= io.Xs ^ io.Ys;
      pz_q    <= 1'b0;
      pi_q    <= 1'b0;
      pn_q    <= 1'b0;
      pv_q    <= 1'b0;
      xz_q    <= io.Xzero;
      xi_q    <= io.Xinf;
      xn_q    <= io.XNaN;
      xsn_q   <= io.XsNaN;
      yz_q    <= io.Yzero;
      yi_q    <= io.Yinf;
      yn_q    <= io.YNaN;
      ysn_q   <= io.YsNaN;
    end else if (state_q == BUSY) begin
      acc_q <= {1'b0, add_d[NBITS:1]};
      mpl_q <= {add_d[0], mpl_q[NBITS-1:1]};
      cnt_q <= cnt_q + 1'b1;
      if (last_it) pm_q <= prod_d;
    end else if (state_q == SPEC) begin
      pm_q <= '0;
      pv_q <= inf_zero | xsn_q | ysn_q;
      if (any_nan | inf_zero) begin
        pn_q <= 1'b1;
        ps_q <= 1'b0;
        pe_q <= '0;
      end else if (xi_q | yi_q) begin
        pi_q <= 1'b1;
      end else begin
        pz_q <= 1'b1;
        pe_q <= '0;
      end
    end
  end

  assign io.Ps       = ps_q;
  assign io.Pe       = pe_q;
  assign io.Pm       = pm_q;
  assign io.Pzero    = pz_q;
  assign io.Pinf     = pi_q;
  assign io.PNaN     = pn_q;
  assign io.Pinvalid = pv_q;

endmodule

// File: tb/tb_fma16_mul_stage.sv
// Bench for fma16_mul_stage: directed and
// random operands against a behavioural model.
module tb_fma16_mul_stage;

  typedef struct packed {
    logic        xs;
    logic        ys;
    logic [4:0]  xe;
    logic [4:0]  ye;
    logic [10:0] xm;
    logic [10:0] ym;
    logic        xz, xi, xn, xsn;
    logic        yz, yi, yn, ysn;
  } op_t;

  typedef struct packed {
    logic        ps;
    logic [6:0]  pe;
    logic [21:0] pm;
    logic        pz, pi, pn, pv;
  } res_t;

  logic clk;
  logic rst_n;
  int   nchk;
  int   nerr;

  fma16_mul_stage_if #(.NBITS(11)) io ();

  fma16_mul_stage #(
    .BIAS (15),
    .NBITS(11)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (io.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic op_t mk(
    input logic xs, input int xe, input int xm,
    input logic ys, input int ye, input int ym
  );
    op_t o;
    o = '0;
    o.xs = xs; o.xe = 5'(xe); o.xm = 11'(xm);
    o.ys = ys; o.ye = 5'(ye); o.ym = 11'(ym);
    return o;
  endfunction

  // reference: rules applied with plain arithmetic
  function automatic res_t model(input op_t o);
    res_t r;
    logic nan, iz, anyinf, anyzero;
    int   e;
    r = '0;
    e = int'(o.xe) + int'(o.ye) - 15;
    nan = o.xn | o.yn | o.xsn | o.ysn;
    iz = (o.xi & o.yz) | (o.yi & o.xz);
    anyinf = o.xi | o.yi;
    anyzero = o.xz | o.yz;
    r.pv = iz | o.xsn | o.ysn;
    if (nan || iz) begin
      r.pn = 1'b1;
    end else if (anyinf) begin
      r.pi = 1'b1;
      r.ps = o.xs ^ o.ys;
      r.pe = 7'(e);
    end else if (anyzero) begin
      r.pz = 1'b1;
      r.ps = o.xs ^ o.ys;
    end else begin
      r.ps = o.xs ^ o.ys;
      r.pe = 7'(e);
      r.pm = 22'(int'(o.xm) * int'(o.ym));
    end
    return r;
  endfunction

  function automatic int exp_lat(input op_t o);
    if (o.xz | o.xi | o.xn | o.xsn |
        o.yz | o.yi | o.yn | o.ysn) return 1;
    return 11;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int  c;
    o = '0;
    o.xs = 1'($urandom);
    o.ys = 1'($urandom);
    o.xe = 5'($urandom_range(1, 30));
    o.ye = 5'($urandom_range(1, 30));
    o.xm = {1'b1, 10'($urandom)};
    o.ym = {1'b1, 10'($urandom)};
    if (o.xe == 5'd1 && $urandom_range(0, 1) == 1)
      o.xm = 11'($urandom_range(0, 1023));
    if (o.ye == 5'd1 && $urandom_range(0, 1) == 1)
      o.ym = 11'($urandom_range(0, 1023));
    c = $urandom_range(0, 11);
    case (c)
      0: begin o.xz = 1'b1; o.xm = '0; end
      1: begin o.xi = 1'b1; o.xe = 5'd31; end
      2: o.xn = 1'b1;
      3: begin o.xn = 1'b1; o.xsn = 1'b1; end
      default: ;
    endcase
    c = $urandom_range(0, 11);
    case (c)
      0: begin o.yz = 1'b1; o.ym = '0; end
      1: begin o.yi = 1'b1; o.ye = 5'd31; end
      2: o.yn = 1'b1;
      3: begin o.yn = 1'b1; o.ysn = 1'b1; end
      default: ;
    endcase
    return o;
  endfunction

  task automatic apply(input op_t o);
    io.Xs = o.xs; io.Ys = o.ys;
    io.Xe = o.xe; io.Ye = o.ye;
    io.Xm = o.xm; io.Ym = o.ym;
    io.Xzero = o.xz; io.Xinf = o.xi;
    io.XNaN = o.xn; io.XsNaN = o.xsn;
    io.Yzero = o.yz; io.Yinf = o.yi;
    io.YNaN = o.yn; io.YsNaN = o.ysn;
  endtask

  task automatic grab(output res_t r);
    r = {io.Ps, io.Pe, io.Pm,
         io.Pzero, io.Pinf, io.PNaN, io.Pinvalid};
  endtask

  // present o at a falling edge, hold until taken
  task automatic accept_op(input op_t o);
    int n;
    n = 0;
    @(negedge clk);
    apply(o);
    io.in_valid = 1'b1;
    while (!io.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    apply(rand_op());
  endtask

  // edges counted from the accepting edge
  task automatic wait_done(output res_t r, output int lat);
    lat = 0;
    while (!io.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    grab(r);
  endtask

  task automatic test_reset();
    res_t r;
    rst_n = 1'b0;
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    apply('0);
    repeat (3) @(posedge clk);
    #1;
    grab(r);
    nchk++;
    if (io.out_valid !== 1'b0 || r !== '0) begin
      nerr++;
      $display("FAIL reset_out: valid=%b res=%h want 0/0",
               io.out_valid, r);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    nchk++;
    if (io.in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL reset_ready: got %b want 1",
               io.in_ready);
    end
  endtask

  task automatic check_op(input string nm, input op_t o);
    res_t r, e;
    int   lat;
    e = model(o);
    accept_op(o);
    wait_done(r, lat);
    nchk++;
    if (lat !== exp_lat(o)) begin
      nerr++;
      $display("FAIL %s_lat: got %0d want %0d",
               nm, lat, exp_lat(o));
    end
    nchk++;
    if (r !== e) begin
      nerr++;
      $display("FAIL %s_res: got %h want %h", nm, r, e);
    end
    @(posedge clk);
    #1;
    nchk++;
    if (io.in_ready !== 1'b1 || io.out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL %s_idle: rdy=%b vld=%b want 1/0",
               nm, io.in_ready, io.out_valid);
    end
  endtask

  task automatic test_normal();
    io.out_ready = 1'b1;
    check_op("one_x_one", mk(0, 15, 'h400, 0, 15, 'h400));
    check_op("neg_mul", mk(1, 15, 'h600, 0, 16, 'h400));
    check_op("max_mul", mk(0, 30, 'h7FF, 1, 30, 'h7FF));
    check_op("sub_sub", mk(0, 1, 'h001, 0, 1, 'h001));
  endtask

  task automatic test_special();
    op_t o;
    io.out_ready = 1'b1;
    o = mk(0, 31, 'h400, 0, 1, 0);
    o.xi = 1'b1; o.yz = 1'b1;
    check_op("inf_zero", o);
    o = mk(1, 31, 'h600, 0, 20, 'h555);
    o.xn = 1'b1; o.xsn = 1'b1;
    check_op("snan", o);
    o = mk(0, 31, 'h400, 1, 17, 'h4AB);
    o.xi = 1'b1;
    check_op("inf_norm", o);
    o = mk(1, 10, 'h5A5, 0, 1, 0);
    o.yz = 1'b1;
    check_op("zero_norm", o);
  endtask

  task automatic test_random();
    io.out_ready = 1'b1;
    for (int i = 0; i < 40; i++)
      check_op("rand", rand_op());
  endtask

  task automatic test_backpressure();
    op_t  o;
    res_t r, h, e;
    int   lat;
    o = mk(0, 20, 'h5C3, 1, 12, 'h6A1);
    e = model(o);
    io.out_ready = 1'b0;
    accept_op(o);
    wait_done(r, lat);
    nchk++;
    if (r !== e || lat !== 11) begin
      nerr++;
      $display("FAIL bp_res: got %h lat %0d want %h lat 11",
               r, lat, e);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      apply(rand_op());
      io.in_valid = 1'b1;
      @(posedge clk);
      #1;
      grab(h);
      nchk++;
      if (h !== e || io.out_valid !== 1'b1 ||
          io.in_ready !== 1'b0) begin
        nerr++;
        $display("FAIL bp_hold: res=%h v=%b r=%b want %h 1 0",
                 h, io.out_valid, io.in_ready, e);
      end
    end
    @(negedge clk);
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    @(posedge clk);
    #1;
    nchk++;
    if (io.out_valid !== 1'b0 || io.in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL bp_release: v=%b r=%b want 0 1",
               io.out_valid, io.in_ready);
    end
  endtask

  task automatic test_reset_mid_busy();
    res_t r;
    int   seen;
    io.out_ready = 1'b1;
    accept_op(mk(0, 18, 'h7A3, 0, 19, 'h65F));
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    grab(r);
    nchk++;
    if (r !== '0 || io.out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL rst_busy: res=%h v=%b want 0 0",
               r, io.out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (io.out_valid) seen++;
    end
    nchk++;
    if (seen !== 0 || io.in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL rst_after: valid_cycles=%0d rdy=%b want 0 1",
               seen, io.in_ready);
    end
    check_op("post_rst", mk(1, 25, 'h4F1, 1, 3, 'h733));
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    rst_n = 1'b0;
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    apply('0);
    test_reset();
    test_normal();
    test_special();
    test_random();
    test_backpressure();
    test_reset_mid_busy();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
